// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin arbiter sharing one 12-bit two's complement -> (S, E[2:0], F[3:0]) converter.
// Define FPCVT_SCHED_STATS_EN to add sat_cnt, a saturating count of E=7,F=15 conversions.
module fpcvt_sched #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic                 res_s,
    output logic [2:0]           res_e,
    output logic [3:0]           res_f,
    output logic                 busy
`ifdef FPCVT_SCHED_STATS_EN
    ,
    output logic [7:0]           sat_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t                 state_q;
    logic [IDW-1:0]         rr_ptr_q;
    logic [IDW-1:0]         id_q;
    logic signed [11:0]     opnd_q;
    logic                   res_valid_q;
    logic [IDW-1:0]         res_id_q;
    logic [7:0]             res_q;
    logic                   hit_d;
    logic [IDW-1:0]         grant_d;
    logic [7:0]             cvt_d;
`ifdef FPCVT_SCHED_STATS_EN
    logic [7:0]             sat_cnt_q;
`endif

    // Magnitude is normalised to 4 significant bits, rounded half-up on the next bit;
    // a carry out of F bumps E, and anything needing E>7 saturates to E=7,F=15.
    function automatic logic [7:0] fpcvt(input logic signed [11:0] x);
        logic [11:0] xu;
        logic [11:0] mag;
        logic [11:0] sh;
        logic [11:0] shr;
        logic [3:0]  ex;
        logic        rb;
        logic [4:0]  fr;
        xu  = x;
        mag = xu[11] ? (~xu + 12'd1) : xu;
        ex  = 4'd0;
        for (int b = 4; b < 12; b++)
            if (mag[b]) ex = 4'(b - 3);
        sh  = mag >> ex;
        shr = (ex == 4'd0) ? 12'd0 : (mag >> (ex - 4'd1));
        rb  = shr[0];
        fr  = {1'b0, sh[3:0]} + {4'd0, rb};
        if (fr[4]) begin
            ex = ex + 4'd1;
            fr = 5'b01000;
        end
        if (ex > 4'd7) return {xu[11], 3'd7, 4'd15};
        return {xu[11], ex[2:0], fr[3:0]};
    endfunction

    // Two passes of a priority search: indices at or above rr_ptr win, otherwise wrap to the lowest.
    always_comb begin
        logic           hi_hit;
        logic [IDW-1:0] hi_idx;
        logic [IDW-1:0] lo_idx;
        hit_d  = 1'b0;
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                hit_d  = 1'b1;
                lo_idx = IDW'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_hit = 1'b1;
                    hi_idx = IDW'(i);
                end
            end
        end
        grant_d = hi_hit ? hi_idx : lo_idx;
    end

    assign cvt_d     = fpcvt(opnd_q);
    assign req_ready = (rst_n && state_q == IDLE && hit_d) ? (NREQ'(1) << grant_d) : '0;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_s     = res_q[7];
    assign res_e     = res_q[6:4];
    assign res_f     = res_q[3:0];
`ifdef FPCVT_SCHED_STATS_EN
    assign sat_cnt   = sat_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= '0;
`ifdef FPCVT_SCHED_STATS_EN
            sat_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit_d) begin
                        opnd_q  <= req_data[int'(grant_d)*12 +: 12];
                        id_q    <= grant_d;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    res_q       <= cvt_d;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= OUT;
`ifdef FPCVT_SCHED_STATS_EN
                    if (cvt_d[6:0] == 7'h7F && sat_cnt_q != 8'hFF)
                        sat_cnt_q <= sat_cnt_q + 8'd1;
`endif
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_ptr_q    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpcvt_sched.sv
// Testbench for fpcvt_sched: directed spec vectors plus randomized transactions against a behavioural model.
module tb_fpcvt_sched;
    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [12*NREQ-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [IDW-1:0]      res_id;
    logic                res_s;
    logic [2:0]          res_e;
    logic [3:0]          res_f;
    logic                busy;
`ifdef FPCVT_SCHED_STATS_EN
    logic [7:0]          sat_cnt;
    int                  sat_model = 0;
`endif

    int tests = 0;
    int fails = 0;
    int rr = 0;

    fpcvt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_s(res_s), .res_e(res_e), .res_f(res_f), .busy(busy)
`ifdef FPCVT_SCHED_STATS_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // value = (-1)^S * F * 2^E, F the 4 leading bits of |v| rounded half-up on the next bit
    function automatic logic [7:0] ref_cvt(input int v);
        int s, mag, e, f, rb;
        s   = (v < 0) ? 1 : 0;
        mag = (v < 0) ? -v : v;
        e   = 0;
        while (mag / (1 << e) >= 16) e++;
        f  = mag / (1 << e);
        rb = (e > 0) ? (mag / (1 << (e - 1))) % 2 : 0;
        f  = f + rb;
        if (f == 16) begin f = 8; e++; end
        if (e > 7) begin e = 7; f = 15; end
        return {s[0], e[2:0], f[3:0]};
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res", {res_id, res_s, res_e, res_f}, 0);
`ifdef FPCVT_SCHED_STATS_EN
        chk("rst_sat", 32'(sat_cnt), 0);
        sat_model = 0;
`endif
        rst_n = 1'b1;
        req_valid = '0;
        rr = 0;
    endtask

    task automatic xact(input logic [NREQ-1:0] v, input logic [11:0] d0, input logic [11:0] d1,
                        input int stall, output int gid, output logic [7:0] got);
        logic [7:0]  exp;
        logic [11:0] smp;
        @(negedge clk);
        req_valid = v;
        req_data  = {d1, d0};
        res_ready = (stall == 0);
        gid = model_grant(v);
        smp = (gid == 0) ? d0 : d1;
        exp = ref_cvt(int'($signed(smp)));
        #1;
        chk("idle_ready", 32'(req_ready), 32'(1) << gid);
        chk("idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        req_data  = {12'($urandom), 12'($urandom)};
        @(negedge clk);
        chk("conv_busy", 32'(busy), 1);
        chk("conv_ready", 32'(req_ready), 0);
        chk("conv_valid", 32'(res_valid), 0);
        @(negedge clk);
        got = {res_s, res_e, res_f};
        chk("out_valid", 32'(res_valid), 1);
        chk("out_id", 32'(res_id), gid);
        chk("out_res", 32'(got), 32'(exp));
`ifdef FPCVT_SCHED_STATS_EN
        if (exp[6:0] == 7'h7F && sat_model < 255) sat_model++;
        chk("sat_cnt", 32'(sat_cnt), sat_model);
`endif
        for (int c = 0; c < stall; c++) begin
            req_valid = '1;
            @(negedge clk);
            chk("hold_res", {res_valid, res_id, res_s, res_e, res_f}, {1'b1, IDW'(gid), exp});
            chk("hold_ready", 32'(req_ready), 0);
            req_valid = '0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", 32'(res_valid), 0);
        chk("done_busy", 32'(busy), 0);
        rr = (gid + 1) % NREQ;
    endtask

    initial begin
        int         gid;
        logic [7:0] got;
        do_reset();

        // no request: stays idle
        @(negedge clk);
        #1;
        chk("noreq_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("noreq_busy", 32'(busy), 0);

        xact(2'b01, 12'h038, 12'h000, 0, gid, got);
        chk("spec_56", 32'(got), 32'h2E);
        xact(2'b10, 12'h000, 12'hFC8, 0, gid, got);
        chk("spec_m56", 32'(got), 32'hAE);
        xact(2'b01, 12'h02E, 12'h000, 0, gid, got);
        chk("spec_46", 32'(got), 32'h2C);
        xact(2'b01, 12'h800, 12'h000, 0, gid, got);
        chk("spec_m2048", 32'(got), 32'hFF);
        xact(2'b01, 12'h7FF, 12'h000, 0, gid, got);
        chk("spec_2047", 32'(got), 32'h7F);
        xact(2'b01, 12'h1A6, 12'h000, 0, gid, got);
        chk("spec_422", 32'(got), 32'h5D);
        xact(2'b10, 12'h000, 12'h000, 0, gid, got);
        chk("spec_zero", 32'(got), 32'h00);

        // both requesting: strict alternation from a fresh pointer
        do_reset();
        for (int i = 0; i < 6; i++) begin
            xact(2'b11, 12'($urandom), 12'($urandom), 0, gid, got);
            chk("rr_seq", 32'(gid), 32'(i % 2));
        end

        // backpressure for 5 cycles
        xact(2'b11, 12'h123, 12'hABC, 5, gid, got);

        // reset while holding a result in OUT
        @(negedge clk);
        req_valid = 2'b01;
        req_data  = {12'h000, 12'h456};
        res_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(res_valid), 1);
        rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_res", {res_id, res_s, res_e, res_f}, 0);
        rst_n = 1'b1;
        req_valid = '0;
        rr = 0;
`ifdef FPCVT_SCHED_STATS_EN
        sat_model = 0;
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            xact(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 12'($urandom), 12'($urandom),
                 int'($urandom_range(0, 3)), gid, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
